// File: rtl/sa_job_arbiter.sv
// Round-robin job arbiter in front of a systolic array: it grants one requester,
// launches the array, and returns the result (or a timeout abort) as one response.
module sa_job_arbiter #(
  parameter int unsigned N       = 8,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 3 * N + 8
) (
  input  logic                                            i_clk,
  input  logic                                            i_arst_n,
  input  logic        [NUM_REQ-1:0]                       i_req_valid,
  output logic        [NUM_REQ-1:0]                       o_req_ready,
  input  logic signed [NUM_REQ-1:0][N-1:0][N-1:0][7:0]    i_req_a,
  input  logic signed [NUM_REQ-1:0][N-1:0][N-1:0][7:0]    i_req_b,
  output logic signed [N-1:0][N-1:0][7:0]                 o_sa_a,
  output logic signed [N-1:0][N-1:0][7:0]                 o_sa_b,
  output logic                                            o_sa_validInput,
  input  logic signed [N-1:0][N-1:0][31:0]                i_sa_c,
  input  logic                                            i_sa_validResult,
  output logic                                            o_rsp_valid,
  input  logic                                            i_rsp_ready,
  output logic        [$clog2(NUM_REQ)-1:0]               o_rsp_id,
  output logic signed [N-1:0][N-1:0][31:0]                o_rsp_c,
  output logic                                            o_rsp_err,
  output logic                                            o_busy
);

  localparam int unsigned IDW     = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                                  state_q, state_d;
  logic        [IDW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic        [IDW-1:0]                   id_q, id_d;
  logic        [15:0]                      cnt_q, cnt_d;
  logic signed [N-1:0][N-1:0][7:0]         op_a_q, op_a_d;
  logic signed [N-1:0][N-1:0][7:0]         op_b_q, op_b_d;
  logic signed [N-1:0][N-1:0][31:0]        rsp_c_q, rsp_c_d;
  logic                                    err_q, err_d;

  logic                                    gnt_found;
  logic        [IDW-1:0]                   gnt_idx;
  logic        [IDW-1:0]                   cand;

  // Upward search from rr_ptr with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    id_d            = id_q;
    cnt_d           = cnt_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    rsp_c_d         = rsp_c_q;
    err_d           = err_q;
    o_req_ready     = '0;
    o_sa_validInput = 1'b0;
    o_rsp_valid     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          o_req_ready[gnt_idx] = 1'b1;
          op_a_d   = i_req_a[gnt_idx];
          op_b_d   = i_req_b[gnt_idx];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        o_sa_validInput = 1'b1;
        cnt_d           = '0;
        state_d         = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        // Result is checked first so a same-cycle timeout loses to it.
        if (i_sa_validResult) begin
          rsp_c_d = i_sa_c;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_c_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      rsp_c_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      rsp_c_q  <= rsp_c_d;
      err_q    <= err_d;
    end
  end

  assign o_sa_a    = op_a_q;
  assign o_sa_b    = op_b_q;
  assign o_rsp_id  = id_q;
  assign o_rsp_c   = rsp_c_q;
  assign o_rsp_err = err_q;
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sa_job_arbiter.sv
// Directed bench for sa_job_arbiter: single job, contention, backpressure,
// timeout, result/timeout collision and reset mid-job.
module tb_sa_job_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned NR = 2;

  logic                                   clk;
  logic                                   rst_n;
  logic        [NR-1:0]                   req_valid;
  logic        [NR-1:0]                   req_ready;
  logic signed [NR-1:0][N-1:0][N-1:0][7:0] req_a;
  logic signed [NR-1:0][N-1:0][N-1:0][7:0] req_b;
  logic signed [N-1:0][N-1:0][7:0]        sa_a;
  logic signed [N-1:0][N-1:0][7:0]        sa_b;
  logic                                   sa_vi;
  logic signed [N-1:0][N-1:0][31:0]       sa_c;
  logic                                   sa_vr;
  logic                                   rsp_valid;
  logic                                   rsp_ready;
  logic        [0:0]                      rsp_id;
  logic signed [N-1:0][N-1:0][31:0]       rsp_c;
  logic                                   rsp_err;
  logic                                   busy;

  int unsigned total;
  int unsigned bad;

  sa_job_arbiter #(
    .N       (N),
    .NUM_REQ (NR),
    .TIMEOUT (3 * N + 8)
  ) dut (
    .i_clk            (clk),
    .i_arst_n         (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_a          (req_a),
    .i_req_b          (req_b),
    .o_sa_a           (sa_a),
    .o_sa_b           (sa_b),
    .o_sa_validInput  (sa_vi),
    .i_sa_c           (sa_c),
    .i_sa_validResult (sa_vr),
    .o_rsp_valid      (rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_id         (rsp_id),
    .o_rsp_c          (rsp_c),
    .o_rsp_err        (rsp_err),
    .o_busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned cnt32(input logic signed [N-1:0][N-1:0][31:0] m,
                                        input logic [31:0] v);
    int unsigned n = 0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        if (m[r][c] === v) n++;
    return n;
  endfunction

  function automatic int unsigned cnt8(input logic signed [N-1:0][N-1:0][7:0] m,
                                       input logic [7:0] v);
    int unsigned n = 0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        if (m[r][c] === v) n++;
    return n;
  endfunction

  function automatic int unsigned ident_cnt(input logic signed [N-1:0][N-1:0][7:0] m);
    int unsigned n = 0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        if (m[r][c] === ((r == c) ? 8'd1 : 8'd0)) n++;
    return n;
  endfunction

  function automatic logic signed [N-1:0][N-1:0][31:0] fill32(input logic [31:0] v);
    logic signed [N-1:0][N-1:0][31:0] m;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++)
        m[r][c] = v;
    return m;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned stable;
    logic        vi_seen;
    int unsigned exp_id;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    sa_vr     = 1'b0;
    sa_c      = '0;
    req_a     = '0;
    req_b     = '0;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) begin
        req_a[0][r][c] = (r == c) ? 8'sd1 : 8'sd0;
        req_b[0][r][c] = 8'sd2;
        req_a[1][r][c] = 8'sd7;
        req_b[1][r][c] = 8'sd3;
      end

    // Reset state
    repeat (2) tick();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_vi",    64'(sa_vi), 64'd0);
    chk("rst_rv",    64'(rsp_valid), 64'd0);
    chk("rst_err",   64'(rsp_err), 64'd0);
    chk("rst_sa_a",  64'(cnt8(sa_a, 8'd0)), 64'd64);
    chk("rst_rsp_c", 64'(cnt32(rsp_c, 32'd0)), 64'd64);
    rst_n = 1'b1;

    // Single job from requester 0
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 64'(req_ready), 64'd1);
    tick();
    chk("t1_launch", 64'(sa_vi), 64'd1);
    chk("t1_busy",   64'(busy), 64'd1);
    chk("t1_sa_a",   64'(ident_cnt(sa_a)), 64'd64);
    chk("t1_sa_b",   64'(cnt8(sa_b, 8'd2)), 64'd64);
    req_valid = 2'b00;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) req_b[0][r][c] = 8'sh55;
    tick();
    chk("t1_pulse_once", 64'(sa_vi), 64'd0);
    chk("t1_hold_b",     64'(cnt8(sa_b, 8'd2)), 64'd64);
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) req_b[0][r][c] = 8'sd2;
    sa_c      = fill32(32'd2);
    sa_vr     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    sa_vr = 1'b0;
    chk("t1_rv",  64'(rsp_valid), 64'd1);
    chk("t1_id",  64'(rsp_id), 64'd0);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_c",   64'(cnt32(rsp_c, 32'd2)), 64'd64);
    tick();
    chk("t1_idle_rv",   64'(rsp_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Contention: pointer now at 1, so grants run 1,0,1,0
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0) ? 1 : 0;
      #1;
      chk("t2_grant", 64'(req_ready), 64'(1 << exp_id));
      tick();
      chk("t2_sa_a", 64'(sa_a[0][0]), (exp_id == 1) ? 64'd7 : 64'd1);
      tick();
      sa_c  = fill32(32'(k + 10));
      sa_vr = 1'b1;
      tick();
      sa_vr = 1'b0;
      chk("t2_id",         64'(rsp_id), 64'(exp_id));
      chk("t2_nogrant_rsp", 64'(req_ready), 64'd0);
      chk("t2_c",          64'(rsp_c[0][0]), 64'(k + 10));
      tick();
    end

    // Backpressure on the response; a stray array pulse in RESP must not disturb it
    rsp_ready = 1'b0;
    #1;
    chk("t3_grant", 64'(req_ready), 64'd2);
    tick();
    tick();
    sa_c  = fill32(32'd9);
    sa_vr = 1'b1;
    tick();
    sa_vr  = 1'b0;
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1 && rsp_id === 1'b1 && rsp_err === 1'b0 &&
          cnt32(rsp_c, 32'd9) == 64 && req_ready === 2'b00)
        stable++;
      if (i == 3) begin
        sa_c  = fill32(32'd77);
        sa_vr = 1'b1;
      end else begin
        sa_vr = 1'b0;
      end
      tick();
    end
    chk("t3_stable", 64'(stable), 64'd10);
    chk("t3_still_rv", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    tick();
    chk("t3_idle_busy", 64'(busy), 64'd0);
    chk("t3_idle_rv",   64'(rsp_valid), 64'd0);
    chk("t3_next_grant", 64'(req_ready), 64'd1);
    req_valid = 2'b00;

    // Timeout: array never answers
    #1;
    req_valid = 2'b01;
    #1;
    chk("t4_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    n       = 0;
    vi_seen = 1'b0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      n++;
      vi_seen = vi_seen | sa_vi;
      tick();
    end
    chk("t4_busy_cycles", 64'(n), 64'd32);
    chk("t4_no_relaunch", 64'(vi_seen), 64'd0);
    chk("t4_err", 64'(rsp_err), 64'd1);
    chk("t4_c",   64'(cnt32(rsp_c, 32'd0)), 64'd64);
    chk("t4_id",  64'(rsp_id), 64'd0);
    tick();

    // Result arrives on the exact timeout cycle; pointer is 1 so search wraps to 0
    req_valid = 2'b01;
    #1;
    chk("t5_grant", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    repeat (31) tick();
    chk("t5_pre_rv",   64'(rsp_valid), 64'd0);
    chk("t5_pre_busy", 64'(busy), 64'd1);
    sa_c  = fill32(32'hFFFF_FFFD);
    sa_vr = 1'b1;
    tick();
    sa_vr = 1'b0;
    chk("t5_rv",  64'(rsp_valid), 64'd1);
    chk("t5_err", 64'(rsp_err), 64'd0);
    chk("t5_c",   64'(cnt32(rsp_c, 32'hFFFF_FFFD)), 64'd64);
    tick();

    // Reset mid-BUSY, then a stale array pulse
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    chk("t6_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rv",   64'(rsp_valid), 64'd0);
    chk("t6_rst_sa_a", 64'(cnt8(sa_a, 8'd0)), 64'd64);
    chk("t6_rst_c",    64'(cnt32(rsp_c, 32'd0)), 64'd64);
    tick();
    rst_n = 1'b1;
    sa_c  = fill32(32'd4);
    sa_vr = 1'b1;
    tick();
    sa_vr = 1'b0;
    chk("t6_stale_rv",   64'(rsp_valid), 64'd0);
    chk("t6_stale_busy", 64'(busy), 64'd0);
    chk("t6_stale_err",  64'(rsp_err), 64'd0);
    chk("t6_stale_c",    64'(cnt32(rsp_c, 32'd0)), 64'd64);
    repeat (3) tick();
    chk("t6_still_idle", 64'(busy), 64'd0);
    req_valid = 2'b11;
    #1;
    chk("t6_ptr_reset", 64'(req_ready), 64'd1);
    req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
